// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the exception FSM states, forward-select codes and defaults.
package hazard_ctrl_pkg;

    typedef enum logic {
        IDLE,
        PEND
    } hc_state_e;

    localparam int FWD_NONE = 0;
    localparam int FWD_M    = 1;
    localparam int FWD_W    = 2;

    localparam int NUM_SRC_DEF    = 2;
    localparam int FWD_STAGES_DEF = 2;
    localparam int REG_AW_DEF     = 5;
    localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forward-select for one E-stage source port.
// The nearest (lowest-index) writing stage wins; r0 is never forwarded.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int FWD_STAGES = FWD_STAGES_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic [REG_AW-1:0]            src_i,
    input  logic [FWD_STAGES-1:0]        wen_i,
    input  logic [FWD_STAGES*REG_AW-1:0] waddr_i,
    output logic [SEL_W-1:0]             sel_o
);

    always_comb begin
        sel_o = SEL_W'(FWD_NONE);
        // Scan from the oldest stage down so the youngest match overrides.
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (wen_i[k-1] && (src_i != '0) &&
                (waddr_i[(k-1)*REG_AW +: REG_AW] == src_i)) begin
                sel_o = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding selects,
// deferred exception flush behind a D-cache stall, and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int FWD_STAGES = FWD_STAGES_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          d_cache_stall,
    input  logic                          alu_stallE,
    input  logic                          flush_jump_conflictE,
    input  logic                          flush_pred_failedM,
    input  logic                          flush_exceptionM,
    input  logic [NUM_SRC*REG_AW-1:0]     srcE,
    input  logic [NUM_SRC*REG_AW-1:0]     srcD,
    input  logic [NUM_SRC-1:0]            src_usedD,
    input  logic                          mem_read_enE,
    input  logic [REG_AW-1:0]             reg_writeE,
    input  logic [FWD_STAGES-1:0]         wen_fwd,
    input  logic [FWD_STAGES*REG_AW-1:0]  waddr_fwd,
    output logic                          stallF,
    output logic                          stallD,
    output logic                          stallE,
    output logic                          stallM,
    output logic                          stallW,
    output logic                          flushF,
    output logic                          flushD,
    output logic                          flushE,
    output logic                          flushM,
    output logic                          flushW,
    output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0] fwd_sel,
    output logic                          exc_pending,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              load_use_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    hc_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, load_use_cnt_q, flush_cnt_q;
    logic             load_use, exc_flush, pend;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_fwd_unit #(
            .FWD_STAGES (FWD_STAGES),
            .REG_AW     (REG_AW),
            .SEL_W      (SEL_W)
        ) u_fwd (
            .src_i   (srcE[i*REG_AW +: REG_AW]),
            .wen_i   (wen_fwd),
            .waddr_i (waddr_fwd),
            .sel_o   (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_usedD[i] && (srcD[i*REG_AW +: REG_AW] == reg_writeE)) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use & mem_read_enE & (reg_writeE != '0);
    end

    // A held flush is dropped as soon as reset is seen, without a pulse.
    assign pend        = (state_q == PEND) & ~rst;
    assign exc_pending = pend;
    assign exc_flush   = (flush_exceptionM | pend) & ~d_cache_stall;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (flush_exceptionM && d_cache_stall) state_d = PEND;
            PEND: if (!d_cache_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stallM = d_cache_stall;
    assign stallW = d_cache_stall;
    assign stallE = d_cache_stall | alu_stallE;
    assign stallD = stallE | load_use;
    assign stallF = stallD & ~exc_flush & ~pend;

    assign flushF = 1'b0;
    assign flushW = 1'b0;
    assign flushD = exc_flush | flush_pred_failedM |
                    (flush_jump_conflictE & ~d_cache_stall);
    assign flushE = exc_flush | ((flush_pred_failedM | load_use) & ~stallE);
    assign flushM = exc_flush | (alu_stallE & ~d_cache_stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            stall_cnt_q    <= '0;
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (stallF)               stall_cnt_q    <= stall_cnt_q + CNT_W'(1);
            if (load_use && !stallE)  load_use_cnt_q <= load_use_cnt_q + CNT_W'(1);
            if (exc_flush)            flush_cnt_q    <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign load_use_cnt = load_use_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int NS = 2;
    localparam int FS = 2;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int SW = $clog2(FS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_cache_stall = 1'b0, alu_stallE = 1'b0;
    logic flush_jump_conflictE = 1'b0, flush_pred_failedM = 1'b0;
    logic flush_exceptionM = 1'b0, mem_read_enE = 1'b0;
    logic [NS*AW-1:0] srcE = '0, srcD = '0;
    logic [NS-1:0]    src_usedD = '0;
    logic [AW-1:0]    reg_writeE = '0;
    logic [FS-1:0]    wen_fwd = '0;
    logic [FS*AW-1:0] waddr_fwd = '0;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushF, flushD, flushE, flushM, flushW;
    logic [NS*SW-1:0] fwd_sel;
    logic             exc_pending;
    logic [CW-1:0]    stall_cnt, load_use_cnt, flush_cnt;

    hazard_ctrl #(
        .NUM_SRC(NS), .FWD_STAGES(FS), .REG_AW(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .d_cache_stall(d_cache_stall), .alu_stallE(alu_stallE),
        .flush_jump_conflictE(flush_jump_conflictE),
        .flush_pred_failedM(flush_pred_failedM),
        .flush_exceptionM(flush_exceptionM),
        .srcE(srcE), .srcD(srcD), .src_usedD(src_usedD),
        .mem_read_enE(mem_read_enE), .reg_writeE(reg_writeE),
        .wen_fwd(wen_fwd), .waddr_fwd(waddr_fwd),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .flushW(flushW),
        .fwd_sel(fwd_sel), .exc_pending(exc_pending),
        .stall_cnt(stall_cnt), .load_use_cnt(load_use_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model state: pending flag and counters as plain ints.
    bit m_pend = 1'b0;
    int m_sc = 0, m_lc = 0, m_fc = 0;

    logic [NS*SW-1:0] e_fwd;
    bit e_lu, e_exc, e_pend;
    bit e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM;

    function automatic void eval();
        e_fwd = '0;
        e_lu  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int s;
            bit found;
            s = int'(srcE[i*AW +: AW]);
            found = 1'b0;
            for (int k = 1; k <= FS; k++) begin
                if (!found && s != 0 && wen_fwd[k-1] &&
                    int'(waddr_fwd[(k-1)*AW +: AW]) == s) begin
                    e_fwd[i*SW +: SW] = SW'(k);
                    found = 1'b1;
                end
            end
            if (mem_read_enE && reg_writeE != 0 && src_usedD[i] &&
                srcD[i*AW +: AW] == reg_writeE)
                e_lu = 1'b1;
        end
        e_pend = m_pend && !rst;
        e_exc  = (flush_exceptionM || e_pend) && !d_cache_stall;
        e_sM   = d_cache_stall;
        e_sE   = d_cache_stall || alu_stallE;
        e_sD   = e_sE || e_lu;
        e_sF   = e_sD && !e_exc && !e_pend;
        e_fD   = e_exc || flush_pred_failedM ||
                 (flush_jump_conflictE && !d_cache_stall);
        e_fE   = e_exc || ((flush_pred_failedM || e_lu) && !e_sE);
        e_fM   = e_exc || (alu_stallE && !d_cache_stall);
    endfunction

    always @(posedge clk) begin
        eval();
        if (rst) begin
            m_pend = 1'b0;
            m_sc = 0; m_lc = 0; m_fc = 0;
        end else begin
            if (e_sF)          m_sc = (m_sc + 1) % (1 << CW);
            if (e_lu && !e_sE) m_lc = (m_lc + 1) % (1 << CW);
            if (e_exc)         m_fc = (m_fc + 1) % (1 << CW);
            if (m_pend) m_pend = d_cache_stall;
            else        m_pend = flush_exceptionM && d_cache_stall;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            eval();
            chk("m_stallF", stallF, e_sF);
            chk("m_stallD", stallD, e_sD);
            chk("m_stallE", stallE, e_sE);
            chk("m_stallM", stallM, e_sM);
            chk("m_stallW", stallW, e_sM);
            chk("m_flushF", flushF, 0);
            chk("m_flushD", flushD, e_fD);
            chk("m_flushE", flushE, e_fE);
            chk("m_flushM", flushM, e_fM);
            chk("m_flushW", flushW, 0);
            chk("m_fwd_sel", fwd_sel, e_fwd);
            chk("m_exc_pending", exc_pending, e_pend);
            chk("m_stall_cnt", stall_cnt, m_sc);
            chk("m_load_use_cnt", load_use_cnt, m_lc);
            chk("m_flush_cnt", flush_cnt, m_fc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        d_cache_stall = 0; alu_stallE = 0;
        flush_jump_conflictE = 0; flush_pred_failedM = 0;
        flush_exceptionM = 0; mem_read_enE = 0;
        srcE = '0; srcD = '0; src_usedD = '0; reg_writeE = '0;
        wen_fwd = '0; waddr_fwd = '0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        step();
        step();
        chk_on = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_exc_pending", exc_pending, 0);

        // Forwarding priority and r0 exclusion.
        step();
        srcE = {5'd0, 5'd5}; wen_fwd = 2'b11; waddr_fwd = {5'd5, 5'd5};
        @(negedge clk);
        chk("fwd_both_match", fwd_sel[SW-1:0], 1);
        step();
        srcE = {5'd0, 5'd0};
        @(negedge clk);
        chk("fwd_r0", fwd_sel[SW-1:0], 0);
        step();
        srcE = {5'd7, 5'd7}; wen_fwd = 2'b10; waddr_fwd = {5'd7, 5'd7};
        @(negedge clk);
        chk("fwd_w_only", fwd_sel, {2'd2, 2'd2});

        // Load-use hazard.
        do_reset();
        mem_read_enE = 1; reg_writeE = 8; srcD = {5'd8, 5'd0};
        src_usedD = 2'b10;
        @(negedge clk);
        chk("lu_stallF", stallF, 1);
        chk("lu_stallD", stallD, 1);
        chk("lu_flushE", flushE, 1);
        step();
        src_usedD = 2'b01;
        @(negedge clk);
        chk("lu_cnt", load_use_cnt, 1);
        chk("lu_unused_stallD", stallD, 0);
        chk("lu_unused_stallF", stallF, 0);
        chk("lu_unused_flushE", flushE, 0);
        step();
        src_usedD = 2'b10; d_cache_stall = 1;
        @(negedge clk);
        chk("lu_dcs_flushE", flushE, 0);

        // Exception deferred behind a D-cache stall.
        do_reset();
        d_cache_stall = 1; flush_exceptionM = 1;
        @(negedge clk);
        chk("exc_c1_pend", exc_pending, 0);
        chk("exc_c1_flush", {flushD, flushE, flushM}, 3'b000);
        for (int c = 2; c <= 3; c++) begin
            step();
            flush_exceptionM = 0;
            @(negedge clk);
            chk("exc_c23_pend", exc_pending, 1);
            chk("exc_c23_flush", {flushD, flushE, flushM}, 3'b000);
        end
        step();
        d_cache_stall = 0;
        @(negedge clk);
        chk("exc_c4_flush", {flushD, flushE, flushM}, 3'b111);
        step();
        @(negedge clk);
        chk("exc_c5_pend", exc_pending, 0);
        chk("exc_c5_flushD", flushD, 0);
        chk("exc_flush_cnt", flush_cnt, 1);

        // Reset while a flush is held.
        do_reset();
        d_cache_stall = 1; flush_exceptionM = 1;
        step();
        flush_exceptionM = 0; rst = 1;
        step();
        rst = 0; d_cache_stall = 0;
        @(negedge clk);
        chk("rstp_pend", exc_pending, 0);
        chk("rstp_flushD", flushD, 0);
        chk("rstp_cnts", {stall_cnt, load_use_cnt, flush_cnt}, 12'h000);

        // ALU stall with mispredict.
        do_reset();
        alu_stallE = 1; flush_pred_failedM = 1;
        @(negedge clk);
        chk("alu_flushD", flushD, 1);
        chk("alu_flushE", flushE, 0);
        chk("alu_flushM", flushM, 1);
        chk("alu_stallE", stallE, 1);

        // Counter wrap with a 4-bit counter.
        do_reset();
        alu_stallE = 1;
        repeat (17) @(posedge clk);
        #1;
        alu_stallE = 0;
        @(negedge clk);
        chk("wrap_stall_cnt", stall_cnt, 1);

        // Randomized traffic; small register range to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            d_cache_stall = ($urandom_range(0, 3) == 0);
            alu_stallE = ($urandom_range(0, 4) == 0);
            flush_jump_conflictE = ($urandom_range(0, 5) == 0);
            flush_pred_failedM = ($urandom_range(0, 5) == 0);
            flush_exceptionM = ($urandom_range(0, 6) == 0);
            mem_read_enE = $urandom_range(0, 1);
            reg_writeE = AW'($urandom_range(0, 3));
            for (int i = 0; i < NS; i++) begin
                srcE[i*AW +: AW] = AW'($urandom_range(0, 3));
                srcD[i*AW +: AW] = AW'($urandom_range(0, 3));
            end
            src_usedD = NS'($urandom);
            wen_fwd = FS'($urandom);
            for (int k = 0; k < FS; k++)
                waddr_fwd[k*AW +: AW] = AW'($urandom_range(0, 3));
        end
        step();
        clear();
        rst = 0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2: number of E-stage and D-stage source register ports.
REQ-002 Parameter FWD_STAGES, default 2: number of forwarding sources; index 1 = M, 2 = W, higher = later stages.
REQ-003 Parameter REG_AW, default 5: register-index width.
REQ-004 Parameter CNT_W, default 32: performance-counter width.
REQ-005 Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_cache_stall  in  1  data-cache miss is stalling M.
- alu_stallE  in  1  multi-cycle ALU op is busy in E.
- flush_jump_conflictE, flush_pred_failedM, flush_exceptionM  in  1 each  redirect requests.
- srcE  in  NUM_SRC*REG_AW  E-stage source indices.
- srcD  in  NUM_SRC*REG_AW  D-stage source indices.
- src_usedD  in  NUM_SRC  D-port i actually reads its register.
- mem_read_enE  in  1  the instruction in E is a load.
- reg_writeE  in  REG_AW  E-stage destination index.
- wen_fwd  in  FWD_STAGES  write enable per forwarding stage.
- waddr_fwd  in  FWD_STAGES*REG_AW  destination per forwarding stage.
- stallF..stallW, flushF..flushW  out  1 each  pipeline control.
- fwd_sel  out  NUM_SRC*$clog2(FWD_STAGES+1)  per-port forward select; 0 = register file.
- exc_pending  out  1  a deferred exception flush is held.
- stall_cnt, load_use_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-006 fwd_sel[i] SHALL be the smallest k with wen_fwd[k], waddr_fwd[k]==srcE[i] and srcE[i]!=0; if no k matches it SHALL be 0. Register 0 SHALL never be forwarded on any port.
REQ-007 load_use SHALL be 1 when mem_read_enE=1, reg_writeE!=0, and for some i, src_usedD[i]=1 and srcD[i]==reg_writeE.
REQ-008 The FSM SHALL have two states. IDLE to PEND when flush_exceptionM=1 and d_cache_stall=1. PEND to IDLE on the first cycle with d_cache_stall=0. exc_pending=1 iff the state is PEND.
REQ-009 exc_flush SHALL be (flush_exceptionM | PEND) & ~d_cache_stall. Exceptions arriving in PEND SHALL merge into the held flush.
REQ-010 Stalls: stallM=stallW=d_cache_stall; stallE=d_cache_stall|alu_stallE; stallD=stallE|load_use; stallF=stallD & ~exc_flush & ~exc_pending.
REQ-011 Flushes: flushF=0; flushW=0.
- flushD=exc_flush | flush_pred_failedM | (flush_jump_conflictE & ~d_cache_stall).
- flushE=exc_flush | ((flush_pred_failedM | load_use) & ~stallE).
- flushM=exc_flush | (alu_stallE & ~d_cache_stall).
REQ-012 The combinational path from inputs to stall, flush and forward outputs SHALL have zero latency. Only the FSM and the counters are registered.
REQ-013 stall_cnt SHALL increment each cycle stallF=1. load_use_cnt SHALL increment each cycle load_use=1 & ~stallE. flush_cnt SHALL increment each cycle exc_flush=1.
REQ-014 Each counter SHALL wrap modulo 2^CNT_W.
REQ-015 load_use together with d_cache_stall SHALL leave flushE=0 (the bubble is withheld while E is frozen).

Reset
REQ-016 On rst=1 at a clock edge: FSM to IDLE; all counters to 0.
REQ-017 During reset, the combinational outputs SHALL follow REQ-006..011 with exc_pending=0.
REQ-018 Reset while in PEND SHALL discard the held flush with no flush pulse.

Structure
REQ-019 A shared package SHALL hold the FSM state enum (IDLE, PEND), the forwarding-select encoding constants (FWD_NONE=0, FWD_M=1, FWD_W=2) and the default parameter values.
REQ-020 One sub-module, hazard_fwd_unit, SHALL implement the REQ-006 priority match for a single source port. hazard_ctrl SHALL instantiate it NUM_SRC times.

Verification
REQ-021 srcE[0]=5, wen_fwd=2'b11, waddr M=5, W=5 -> fwd_sel[0]=1. Repeat with srcE[0]=0 -> fwd_sel[0]=0.
REQ-022 mem_read_enE=1, reg_writeE=8, srcD[1]=8, src_usedD=2'b10 -> stallF=stallD=1, flushE=1, load_use_cnt +1 after the edge. Repeat with src_usedD=2'b01 -> no stall.
REQ-023 d_cache_stall=1 for 3 cycles with a flush_exceptionM pulse in cycle 1 -> exc_pending=1 in cycles 2-3, flushD/E/M=0 in cycles 1-3, a single flush pulse in cycle 4 when the stall drops, then IDLE; flush_cnt=1.
REQ-024 rst asserted in cycle 2 of the REQ-023 scenario -> exc_pending=0 from the next cycle, no flush pulse, all counters 0.
REQ-025 alu_stallE=1 with flush_pred_failedM=1 -> flushD=1, flushE=0, flushM=1, stallE=1.
REQ-026 With CNT_W=4, hold stallF for 17 cycles -> stall_cnt=1 (wrapped).
